// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 NTT with a fixed-latency PE.
// Optional macro NTT_CTRL_CYCLE_CNT_EN adds a 32-bit busy-cycle counter output.
module ntt_stage_ctrl #(
    parameter int N      = 256,
    parameter int LOG_N  = 8,
    parameter int PE_LAT = 5,
    parameter int ADDR_W = LOG_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_top_o,
    output logic [ADDR_W-1:0] rd_addr_bot_o,
    output logic [ADDR_W-1:0] tw_addr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_top_o,
    output logic [ADDR_W-1:0] wr_addr_bot_o,
    output logic [ADDR_W-1:0] stage_o
`ifdef NTT_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]       cycle_cnt_o
`endif
);

    localparam int                CNT_W  = $clog2(PE_LAT) + 1;
    localparam logic [ADDR_W-1:0] J_LAST = ADDR_W'(N / 2 - 1);
    localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(LOG_N - 1);
    localparam logic [CNT_W-1:0]  D_LAST = CNT_W'(PE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] s_q, s_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DRAIN: begin
                // Waiting out the PE pipeline keeps the next stage's reads behind this stage's writes.
                if (cnt_q == D_LAST) begin
                    cnt_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    logic              rd_en;
    logic [ADDR_W-1:0] len, grp, kk, top, bot, tw;

    assign rd_en = (state_q == RUN);

    // len = N>>(s+1) is a power of two, so j/len and j%len reduce to shift and mask.
    always_comb begin
        len = ADDR_W'(N >> (s_q + 1'b1));
        grp = j_q >> (S_LAST - s_q);
        kk  = j_q & (len - 1'b1);
        top = (grp << (ADDR_W'(LOG_N) - s_q)) | kk;
        bot = top + len;
        tw  = (ADDR_W'(1) << s_q) + grp;
    end

    assign rd_en_o       = rd_en;
    assign rd_addr_top_o = rd_en ? top : '0;
    assign rd_addr_bot_o = rd_en ? bot : '0;
    assign tw_addr_o     = rd_en ? tw  : '0;
    assign busy_o        = (state_q == RUN) || (state_q == DRAIN);
    assign done_o        = (state_q == DONE);
    assign stage_o       = s_q;

    logic [PE_LAT-1:0]             dly_en_q;
    logic [PE_LAT-1:0][ADDR_W-1:0] dly_top_q;
    logic [PE_LAT-1:0][ADDR_W-1:0] dly_bot_q;

    // Addresses enter already zeroed when idle, so write addresses are zero whenever wr_en_o is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_en_q  <= '0;
            dly_top_q <= '0;
            dly_bot_q <= '0;
        end else begin
            dly_en_q[0]  <= rd_en;
            dly_top_q[0] <= rd_addr_top_o;
            dly_bot_q[0] <= rd_addr_bot_o;
            for (int i = 1; i < PE_LAT; i++) begin
                dly_en_q[i]  <= dly_en_q[i-1];
                dly_top_q[i] <= dly_top_q[i-1];
                dly_bot_q[i] <= dly_bot_q[i-1];
            end
        end
    end

    assign wr_en_o       = dly_en_q[PE_LAT-1];
    assign wr_addr_top_o = dly_top_q[PE_LAT-1];
    assign wr_addr_bot_o = dly_bot_q[PE_LAT-1];

`ifdef NTT_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == IDLE && start_i) begin
            cyc_d = '0;
        end else if (busy_o) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_cnt_o = cyc_q;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl at N=8, PE_LAT=5: read/write sequencing, reset and restart.
module tb_ntt_stage_ctrl;

    localparam int N      = 8;
    localparam int LOG_N  = 3;
    localparam int PE_LAT = 5;
    localparam int AW     = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, rd_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_top_o, rd_addr_bot_o, tw_addr_o;
    logic [AW-1:0] wr_addr_top_o, wr_addr_bot_o, stage_o;
`ifdef NTT_CTRL_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt_o;
`endif

    ntt_stage_ctrl #(.N(N), .LOG_N(LOG_N), .PE_LAT(PE_LAT), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rd_en_o       (rd_en_o),
        .rd_addr_top_o (rd_addr_top_o),
        .rd_addr_bot_o (rd_addr_bot_o),
        .tw_addr_o     (tw_addr_o),
        .wr_en_o       (wr_en_o),
        .wr_addr_top_o (wr_addr_top_o),
        .wr_addr_bot_o (wr_addr_bot_o),
        .stage_o       (stage_o)
`ifdef NTT_CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    wire [4+6*AW-1:0] outs_w = {busy_o, done_o, rd_en_o, wr_en_o, rd_addr_top_o, rd_addr_bot_o,
                                tw_addr_o, wr_addr_top_o, wr_addr_bot_o, stage_o};

    typedef struct {
        int t;
        int stage;
        int top;
        int bot;
        int tw;
    } ev_t;

    ev_t rq[$];
    ev_t wq[$];

    int n_cmp = 0;
    int n_err = 0;

    int exp_top [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int exp_bot [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int exp_tw  [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

    // Expected events relative to the start cycle (tick 0): stage s, butterfly j reads at 1 + s*(N/2+PE_LAT) + j.
    function automatic void push_expected();
        ev_t e;
        for (int i = 0; i < 12; i++) begin
            e.t     = 1 + (i / 4) * (N / 2 + PE_LAT) + (i % 4);
            e.stage = i / 4;
            e.top   = exp_top[i];
            e.bot   = exp_bot[i];
            e.tw    = exp_tw[i];
            rq.push_back(e);
            e.t = e.t + PE_LAT;
            wq.push_back(e);
        end
    endfunction

    task automatic test_reset();
        #1;
        n_cmp++;
        if (outs_w !== '0)
            $display("FAIL reset_outs: got %h want 0", outs_w);
`ifdef NTT_CTRL_CYCLE_CNT_EN
        n_cmp++;
        if (cycle_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", cycle_cnt_o);
        end
`endif
        if (outs_w !== '0) n_err++;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if (outs_w !== '0) begin
                n_err++;
                $display("FAIL idle_outs: got %h want 0", outs_w);
            end
        end
    endtask

    task automatic test_sequence();
        ev_t e;
        start_i = 1'b1;
        push_expected();
        for (int t = 1; t <= 32; t++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (rd_en_o) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_extra: read at tick %0d, none expected", t);
                end else begin
                    e = rq.pop_front();
                    if (t !== e.t || int'(rd_addr_top_o) !== e.top || int'(rd_addr_bot_o) !== e.bot ||
                        int'(tw_addr_o) !== e.tw || int'(stage_o) !== e.stage) begin
                        n_err++;
                        $display("FAIL rd_seq: got t=%0d (%0d,%0d,%0d) s=%0d want t=%0d (%0d,%0d,%0d) s=%0d",
                                 t, rd_addr_top_o, rd_addr_bot_o, tw_addr_o, stage_o,
                                 e.t, e.top, e.bot, e.tw, e.stage);
                    end
                end
            end else begin
                n_cmp++;
                if ({rd_addr_top_o, rd_addr_bot_o, tw_addr_o} !== '0) begin
                    n_err++;
                    $display("FAIL rd_idle_zero: tick %0d got (%0d,%0d,%0d) want 0",
                             t, rd_addr_top_o, rd_addr_bot_o, tw_addr_o);
                end
            end
            if (wr_en_o) begin
                n_cmp++;
                if (wq.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_extra: write at tick %0d, none expected", t);
                end else begin
                    e = wq.pop_front();
                    if (t !== e.t || int'(wr_addr_top_o) !== e.top || int'(wr_addr_bot_o) !== e.bot) begin
                        n_err++;
                        $display("FAIL wr_seq: got t=%0d (%0d,%0d) want t=%0d (%0d,%0d)",
                                 t, wr_addr_top_o, wr_addr_bot_o, e.t, e.top, e.bot);
                    end
                end
            end else begin
                n_cmp++;
                if ({wr_addr_top_o, wr_addr_bot_o} !== '0) begin
                    n_err++;
                    $display("FAIL wr_idle_zero: tick %0d got (%0d,%0d) want 0", t, wr_addr_top_o, wr_addr_bot_o);
                end
            end
            n_cmp++;
            if (busy_o !== (t <= 27)) begin
                n_err++;
                $display("FAIL busy: tick %0d got %0b want %0b", t, busy_o, (t <= 27));
            end
            n_cmp++;
            if (done_o !== (t == 28)) begin
                n_err++;
                $display("FAIL done: tick %0d got %0b want %0b", t, done_o, (t == 28));
            end
            if (t >= 29) begin
                n_cmp++;
                if (stage_o !== '0) begin
                    n_err++;
                    $display("FAIL stage_idle: tick %0d got %0d want 0", t, stage_o);
                end
            end
`ifdef NTT_CTRL_CYCLE_CNT_EN
            if (t >= 28) begin
                n_cmp++;
                if (cycle_cnt_o !== 32'd27) begin
                    n_err++;
                    $display("FAIL cycle_cnt: tick %0d got %0d want 27", t, cycle_cnt_o);
                end
            end
`endif
        end
        n_cmp++;
        if (rq.size() != 0 || wq.size() != 0) begin
            n_err++;
            $display("FAIL seq_leftover: got %0d reads %0d writes pending want 0", rq.size(), wq.size());
        end
        rq.delete();
        wq.delete();
    endtask

    task automatic test_start_held();
        int n_rd = 0;
        int n_wr = 0;
        int done_t = -1;
        int n_done = 0;
        start_i = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (t == 26) start_i = 1'b0;
            if (rd_en_o) n_rd++;
            if (wr_en_o) n_wr++;
            if (done_o) begin
                n_done++;
                done_t = t;
            end
        end
        n_cmp++;
        if (n_rd !== 12) begin
            n_err++;
            $display("FAIL held_reads: got %0d want 12", n_rd);
        end
        n_cmp++;
        if (n_wr !== 12) begin
            n_err++;
            $display("FAIL held_writes: got %0d want 12", n_wr);
        end
        n_cmp++;
        if (n_done !== 1 || done_t !== 28) begin
            n_err++;
            $display("FAIL held_done: got %0d pulses at tick %0d want 1 at tick 28", n_done, done_t);
        end
    endtask

    task automatic test_mid_reset();
        ev_t e;
        start_i = 1'b1;
        push_expected();
        for (int t = 1; t <= 11; t++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (rd_en_o) begin
                e = rq.pop_front();
                n_cmp++;
                if (t !== e.t || int'(rd_addr_top_o) !== e.top || int'(tw_addr_o) !== e.tw) begin
                    n_err++;
                    $display("FAIL mr_rd: got t=%0d top=%0d tw=%0d want t=%0d top=%0d tw=%0d",
                             t, rd_addr_top_o, tw_addr_o, e.t, e.top, e.tw);
                end
            end
            if (wr_en_o) begin
                e = wq.pop_front();
                n_cmp++;
                if (t !== e.t || int'(wr_addr_top_o) !== e.top) begin
                    n_err++;
                    $display("FAIL mr_wr: got t=%0d top=%0d want t=%0d top=%0d", t, wr_addr_top_o, e.t, e.top);
                end
            end
        end
        n_cmp++;
        if (rq.size() !== 6) begin
            n_err++;
            $display("FAIL mr_reads_before_abort: got %0d pending want 6", rq.size());
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (outs_w !== '0) begin
            n_err++;
            $display("FAIL mr_async_clear: got %h want 0", outs_w);
        end
        rq.delete();
        wq.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rd_en_o, wr_en_o, busy_o, done_o} !== 4'b0) begin
                n_err++;
                $display("FAIL mr_after_release: tick %0d got rd=%0b wr=%0b busy=%0b done=%0b want 0",
                         t, rd_en_o, wr_en_o, busy_o, done_o);
            end
        end
    endtask

    task automatic test_done_restart();
        int done_t = -1;
        start_i = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (done_o) done_t = t;
        end
        n_cmp++;
        if (done_t !== 28) begin
            n_err++;
            $display("FAIL dr_done: got tick %0d want 28", done_t);
        end
        start_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rd_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL dr_ignored: got rd=%0b busy=%0b done=%0b want 0", rd_en_o, busy_o, done_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        n_cmp++;
        if (rd_en_o !== 1'b1 || rd_addr_top_o !== 3'd0 || rd_addr_bot_o !== 3'd4 || tw_addr_o !== 3'd1) begin
            n_err++;
            $display("FAIL dr_restart: got rd=%0b (%0d,%0d,%0d) want rd=1 (0,4,1)",
                     rd_en_o, rd_addr_top_o, rd_addr_bot_o, tw_addr_o);
        end
`ifdef NTT_CTRL_CYCLE_CNT_EN
        n_cmp++;
        if (cycle_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL dr_cnt_clear: got %0d want 0", cycle_cnt_o);
        end
`endif
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_start_held();
        test_mid_reset();
        test_sequence();
        test_done_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- N, 256, transform length; a power of two, at least 4.
- LOG_N, 8, number of stages; equals log2(N).
- PE_LAT, 5, pipeline latency in cycles of the PE_Tilde butterfly, at least 1.
- ADDR_W, LOG_N, width of the coefficient and twiddle addresses.

REQ-002 Ports SHALL be as follows, one per line:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- start_i, input, 1, request to run one full NTT.
- busy_o, output, 1, high while stages are executing.
- done_o, output, 1, one-cycle pulse when the transform is complete.
- rd_en_o, output, 1, issues one butterfly read to memory and PE.
- rd_addr_top_o, output, ADDR_W, top coefficient read index.
- rd_addr_bot_o, output, ADDR_W, bottom coefficient read index.
- tw_addr_o, output, ADDR_W, twiddle ROM index.
- wr_en_o, output, 1, PE result write-back strobe.
- wr_addr_top_o, output, ADDR_W, top write-back index.
- wr_addr_bot_o, output, ADDR_W, bottom write-back index.
- stage_o, output, ADDR_W, current stage number, 0 to LOG_N-1.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-004 IDLE->RUN SHALL happen on start_i=1; start_i SHALL be ignored in every other state.
REQ-005 In RUN, rd_en_o=1 every cycle; butterfly index j counts 0..N/2-1; RUN->DRAIN after j=N/2-1.
REQ-006 Addresses for stage s SHALL be: len=N>>(s+1), g=j/len, k=j%len; top=2*g*len+k; bot=top+len; tw=(1<<s)+g.
REQ-007 DRAIN SHALL last exactly PE_LAT cycles with rd_en_o=0.
REQ-008 DRAIN SHALL then go to RUN with s+1 and j=0, or to DONE when s=LOG_N-1.
REQ-009 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-010 busy_o SHALL be 1 exactly in RUN and DRAIN.
REQ-011 wr_en_o and the wr_addr outputs SHALL equal rd_en_o and the rd_addr outputs delayed by exactly PE_LAT cycles, through a cleared delay line.
REQ-012 The last write of a stage SHALL occur one cycle before the first read of the next stage, so there is no read-after-write hazard.
REQ-013 Total busy time SHALL be LOG_N*(N/2+PE_LAT) cycles.
REQ-014 The first rd_en_o SHALL occur in the cycle after start_i is accepted.
REQ-015 When rd_en_o=0, the rd_addr and tw_addr outputs SHALL be 0; when wr_en_o=0, the wr_addr outputs SHALL be 0.
REQ-016 stage_o SHALL be held at 0 in IDLE.
REQ-017 start_i asserted in the same cycle as done_o SHALL be ignored.

Reset
REQ-018 reset=0 SHALL immediately force IDLE and clear s, j and the delay line.
REQ-019 During reset every output SHALL be 0.
REQ-020 A reset in the middle of a run SHALL abort it with no later wr_en_o, and a new start_i SHALL be needed after reset is released.

Configuration
REQ-021 With NTT_CTRL_CYCLE_CNT_EN defined, the block SHALL add output cycle_cnt_o[31:0]:
- cleared on start acceptance;
- incremented every busy_o cycle;
- held after done_o until the next start;
- reset to 0.
REQ-022 Without NTT_CTRL_CYCLE_CNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 N=8, PE_LAT=5, pulse start_i -> read (top,bot,tw) sequence SHALL be:
- stage 0: (0,4,1), (1,5,1), (2,6,1), (3,7,1);
- stage 1: (0,2,2), (1,3,2), (4,6,3), (5,7,3);
- stage 2: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
REQ-024 Same configuration -> wr_en_o mirrors rd_en_o 5 cycles later; done_o pulses 27 cycles after the first rd_en_o; cycle_cnt_o=27 when the macro is defined.
REQ-025 start_i held high during a run -> no restart, and exactly 12 reads in total.
REQ-026 reset=0 asserted at the 6th read cycle -> all outputs 0 at once, no wr_en_o after release, IDLE until the next start_i.
REQ-027 N=8, with PE_Tilde (q=7681) and RAM in the loop -> the final RAM contents match the golden NTT vectors, with no RAW mismatch at stage boundaries.
REQ-028 start_i in the DONE cycle -> ignored; a start_i one cycle later -> a new run begins.
